// File: rtl/uc_irq_if.sv
// uc_irq bus: instruction/flag/irq inputs and datapath control outputs.
// master drives instruction side, slave is the control unit.
interface uc_irq_if #(
  parameter int N_IRQ = 4,
  parameter int PC_W  = 10
);
  logic [15:0]      opcode;
  logic             z;
  logic [N_IRQ-1:0] irq;
  logic             s_inc;
  logic             pc_hold;
  logic             s_vec;
  logic             s_reti;
  logic             s_ret;
  logic [PC_W-1:0]  vec_addr;
  logic             we3;
  logic             wez;
  logic             we4;
  logic             we5;
  logic             push;
  logic             pop;
  logic             s_pila;
  logic             s_out;
  logic [1:0]       s_port;
  logic [1:0]       s_inm;
  logic [2:0]       op_alu;
  logic [N_IRQ-1:0] irq_ack;
  logic             in_isr;

  modport master (
    output opcode, z, irq,
    input  s_inc, pc_hold, s_vec, s_reti, s_ret,
    input  vec_addr, we3, wez, we4, we5, push, pop,
    input  s_pila, s_out, s_port, s_inm, op_alu,
    input  irq_ack, in_isr
  );

  modport slave (
    input  opcode, z, irq,
    output s_inc, pc_hold, s_vec, s_reti, s_ret,
    output vec_addr, we3, wez, we4, we5, push, pop,
    output s_pila, s_out, s_port, s_inm, op_alu,
    output irq_ack, in_isr
  );
endinterface

// File: rtl/uc_irq.sv
// Control unit: opcode decoder plus a registered
// interrupt sequencer (take, push PC, load vector).
module uc_irq #(
  parameter int N_IRQ = 4,
  parameter int PC_W  = 10,
  parameter logic [PC_W-1:0] VEC_BASE = 10'h3F0
) (
  input logic     clk,
  input logic     reset,
  uc_irq_if.slave bus
);
  localparam int SEL_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {
    RUN,
    IRQ_PUSH,
    IRQ_VEC
  } state_t;

  state_t           state;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] armed;
  logic [N_IRQ-1:0] ack;
  logic             gie;
  logic             in_isr_q;
  logic             take;
  logic             is_ei;
  logic             is_di;
  logic             is_reti;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] sel_q;
  logic             unused_op;

  assign armed     = pending & mask;
  assign take      = gie & ~in_isr_q & (|armed);
  assign unused_op = ^bus.opcode;
  assign bus.in_isr  = reset & in_isr_q;
  assign bus.irq_ack = ack;

  // Lowest-numbered armed line wins.
  always_comb begin
    sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (armed[i]) sel = SEL_W'(i);
    end
  end

  // Datapath selects: decode in RUN, fixed patterns in the entry sequence.
  always_comb begin
    bus.s_inc    = 1'b0;
    bus.pc_hold  = 1'b0;
    bus.s_vec    = 1'b0;
    bus.s_reti   = 1'b0;
    bus.s_ret    = 1'b0;
    bus.vec_addr = '0;
    bus.we3      = 1'b0;
    bus.wez      = 1'b0;
    bus.we4      = 1'b0;
    bus.we5      = 1'b0;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;
    bus.s_pila   = 1'b0;
    bus.s_out    = 1'b0;
    bus.s_port   = 2'b00;
    bus.s_inm    = 2'b00;
    bus.op_alu   = 3'b000;
    ack          = '0;
    is_ei        = 1'b0;
    is_di        = 1'b0;
    is_reti      = 1'b0;
    if (!reset) begin
      bus.pc_hold = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (take) begin
            bus.pc_hold = 1'b1;
          end else begin
            bus.s_inc = 1'b1;
            unique casez (bus.opcode[15:10])
              6'b0?????: begin
                bus.op_alu = bus.opcode[14:12];
                bus.we3    = 1'b1;
                bus.wez    = 1'b1;
              end
              6'b100000: begin
                bus.we3   = 1'b1;
                bus.s_inm = 2'b01;
              end
              6'b100001: bus.s_inc = 1'b0;
              6'b100010: bus.s_inc = ~bus.z;
              6'b100011: bus.s_inc = bus.z;
              6'b100100: bus.push = 1'b1;
              6'b100101: begin
                bus.pop    = 1'b1;
                bus.s_pila = 1'b1;
              end
              6'b100110: begin
                bus.we3    = 1'b1;
                bus.s_inm  = 2'b11;
                bus.s_port = bus.opcode[5:4];
              end
              6'b100111: bus.we5 = 1'b1;
              6'b101000: begin
                bus.we5   = 1'b1;
                bus.s_out = 1'b1;
              end
              6'b101001: bus.s_out = 1'b1;
              6'b101010: is_ei = 1'b1;
              6'b101011: is_di = 1'b1;
              6'b101100: begin
                bus.pop    = 1'b1;
                bus.s_reti = 1'b1;
                is_reti    = 1'b1;
              end
              6'b111000: begin
                bus.we3   = 1'b1;
                bus.s_inm = 2'b10;
              end
              6'b1111??: bus.we4 = 1'b1;
              default: ;
            endcase
          end
        end
        IRQ_PUSH: begin
          bus.push    = 1'b1;
          bus.s_ret   = 1'b1;
          bus.pc_hold = 1'b1;
        end
        IRQ_VEC: begin
          bus.s_vec    = 1'b1;
          bus.vec_addr = VEC_BASE + PC_W'(sel_q);
          ack          = N_IRQ'(1) << sel_q;
        end
        default: bus.pc_hold = 1'b1;
      endcase
    end
  end

  // Edge capture, enable state and entry sequencer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      irq_q    <= '0;
      pending  <= '0;
      mask     <= '0;
      gie      <= 1'b0;
      in_isr_q <= 1'b0;
      sel_q    <= '0;
    end else begin
      irq_q   <= bus.irq;
      pending <= (pending & ~ack) | (bus.irq & ~irq_q);
      unique case (state)
        RUN: begin
          if (take) begin
            state <= IRQ_PUSH;
          end else begin
            if (is_ei) begin
              mask <= bus.opcode[N_IRQ-1:0];
              gie  <= 1'b1;
            end
            if (is_di) gie <= 1'b0;
            if (is_reti) in_isr_q <= 1'b0;
          end
        end
        IRQ_PUSH: begin
          sel_q <= sel;
          state <= IRQ_VEC;
        end
        IRQ_VEC: begin
          in_isr_q <= 1'b1;
          state    <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_uc_irq.sv
// Bench for uc_irq: decode table, directed irq
// sequences and a random run against a cycle model.
module tb_uc_irq;
  logic clk = 1'b0;
  logic reset = 1'b0;

  uc_irq_if bus ();

  uc_irq dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] op_c  = 16'h0;
  logic        z_c   = 1'b0;
  logic [3:0]  irq_c = 4'h0;

  // Order: s_inc pc_hold s_vec s_reti s_ret | we3 wez we4 we5 |
  //        push pop s_pila s_out | s_port | s_inm | op_alu
  typedef logic [19:0] out_t;

  typedef struct {
    logic [15:0] op;
    logic        z;
    out_t        exp;
  } vec_t;

  function automatic out_t get_out();
    return {bus.s_inc, bus.pc_hold, bus.s_vec, bus.s_reti, bus.s_ret,
            bus.we3, bus.wez, bus.we4, bus.we5,
            bus.push, bus.pop, bus.s_pila, bus.s_out,
            bus.s_port, bus.s_inm, bus.op_alu};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [15:0] op, input logic zz,
                      input logic [3:0] iv);
    @(posedge clk);
    #1;
    op_c = op;
    z_c = zz;
    irq_c = iv;
    bus.opcode = op;
    bus.z = zz;
    bus.irq = iv;
    #1;
  endtask

  // Called in the take cycle; ends in the vector cycle.
  task automatic entry(input int line, input string nm,
                       input logic [3:0] irq_at_vec);
    logic [9:0] va;
    logic [3:0] ak;
    va = 10'h3F0 + 10'(line);
    ak = 4'b0001 << line;
    chk({nm, "_take"}, {bus.pc_hold, bus.push, bus.we3, bus.s_vec},
        4'b1000);
    step(op_c, z_c, irq_c);
    chk({nm, "_push"}, {bus.pc_hold, bus.push, bus.s_ret, bus.s_vec},
        4'b1110);
    step(op_c, z_c, irq_at_vec);
    chk({nm, "_vec"}, {bus.s_vec, bus.pc_hold, bus.vec_addr, bus.irq_ack},
        {1'b1, 1'b0, va, ak});
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    tbl.push_back('{16'h1234, 1'b0, 20'b10000_1100_0000_00_00_001});
    tbl.push_back('{16'h7FFF, 1'b0, 20'b10000_1100_0000_00_00_111});
    tbl.push_back('{16'h8000, 1'b0, 20'b10000_1000_0000_00_01_000});
    tbl.push_back('{16'h8400, 1'b0, 20'b00000_0000_0000_00_00_000});
    tbl.push_back('{16'h8800, 1'b1, 20'b00000_0000_0000_00_00_000});
    tbl.push_back('{16'h8800, 1'b0, 20'b10000_0000_0000_00_00_000});
    tbl.push_back('{16'h8C00, 1'b1, 20'b10000_0000_0000_00_00_000});
    tbl.push_back('{16'h8C00, 1'b0, 20'b00000_0000_0000_00_00_000});
    tbl.push_back('{16'h9000, 1'b0, 20'b10000_0000_1000_00_00_000});
    tbl.push_back('{16'h9400, 1'b0, 20'b10000_0000_0110_00_00_000});
    tbl.push_back('{16'h9830, 1'b0, 20'b10000_1000_0000_11_11_000});
    tbl.push_back('{16'h9C00, 1'b0, 20'b10000_0001_0000_00_00_000});
    tbl.push_back('{16'hA000, 1'b0, 20'b10000_0001_0001_00_00_000});
    tbl.push_back('{16'hA400, 1'b0, 20'b10000_0000_0001_00_00_000});
    tbl.push_back('{16'hAC00, 1'b0, 20'b10000_0000_0000_00_00_000});
    tbl.push_back('{16'hB000, 1'b0, 20'b10010_0000_0100_00_00_000});
    tbl.push_back('{16'hE000, 1'b0, 20'b10000_1000_0000_00_10_000});
    tbl.push_back('{16'hF000, 1'b0, 20'b10000_0010_0000_00_00_000});
    tbl.push_back('{16'hFFFF, 1'b1, 20'b10000_0010_0000_00_00_000});
    tbl.push_back('{16'hBC00, 1'b0, 20'b10000_0000_0000_00_00_000});
    tbl.push_back('{16'hE400, 1'b0, 20'b10000_0000_0000_00_00_000});

    bus.opcode = 16'h1234;
    bus.z = 1'b0;
    bus.irq = 4'h0;

    // Reset held low: everything idle except pc_hold.
    reset = 1'b0;
    step(16'h1234, 1'b0, 4'h0);
    step(16'h1234, 1'b0, 4'h0);
    chk("rst_out", get_out(), 20'b01000_0000_0000_00_00_000);
    chk("rst_misc", {bus.irq_ack, bus.in_isr, bus.vec_addr}, 64'h0);
    reset = 1'b1;

    // Decode table.
    foreach (tbl[i]) begin
      step(tbl[i].op, tbl[i].z, 4'h0);
      chk($sformatf("dec_%h_z%0d", tbl[i].op, tbl[i].z),
          {get_out(), bus.irq_ack, bus.in_isr, bus.vec_addr},
          {tbl[i].exp, 15'h0});
    end

    // Single line entry.
    step(16'hA80F, 1'b0, 4'h0);
    step(16'h1234, 1'b0, 4'b0100);
    chk("t2_pre", {bus.pc_hold, bus.we3}, 2'b01);
    step(16'h1234, 1'b0, 4'h0);
    entry(2, "t2", 4'h0);
    step(16'h1234, 1'b0, 4'h0);
    chk("t2_isr", {bus.in_isr, bus.we3, bus.pc_hold}, 3'b110);
    step(16'hB000, 1'b0, 4'h0);
    chk("t2_reti", {bus.s_reti, bus.pop, bus.in_isr}, 3'b111);
    step(16'h1234, 1'b0, 4'h0);
    chk("t2_post", {bus.in_isr, bus.pc_hold}, 2'b00);

    // Simultaneous lines 1 and 3, then a rise on 0 inside the ISR.
    step(16'h1234, 1'b0, 4'b1010);
    chk("t3_pre", bus.pc_hold, 1'b0);
    step(16'h1234, 1'b0, 4'b1010);
    entry(1, "t3a", 4'b1010);
    step(16'h1234, 1'b0, 4'b1010);
    chk("t3_nonest", {bus.in_isr, bus.pc_hold, bus.push}, 3'b100);
    step(16'hB000, 1'b0, 4'b1010);
    step(16'h1234, 1'b0, 4'b1010);
    entry(3, "t3b", 4'b1010);
    for (int k = 0; k < 3; k++) begin
      step(16'h1234, 1'b0, 4'b0001);
      chk($sformatf("t4_hold%0d", k),
          {bus.in_isr, bus.pc_hold, bus.push}, 3'b100);
    end
    step(16'hB000, 1'b0, 4'b0001);
    chk("t4_reti", bus.s_reti, 1'b1);
    step(16'h1234, 1'b0, 4'b0001);
    entry(0, "t4", 4'b0001);
    step(16'h1234, 1'b0, 4'h0);
    step(16'hB000, 1'b0, 4'h0);

    // DI blocks entry; EI releases it; set beats ack.
    step(16'hAC00, 1'b0, 4'h0);
    step(16'h1234, 1'b0, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      step(16'h1234, 1'b0, 4'h0);
      chk($sformatf("t5_di%0d", k), {bus.pc_hold, bus.push}, 2'b00);
    end
    step(16'hA80F, 1'b0, 4'h0);
    chk("t5_ei", bus.pc_hold, 1'b0);
    step(16'h1234, 1'b0, 4'h0);
    entry(2, "t5", 4'b0100);
    step(16'h1234, 1'b0, 4'b0100);
    step(16'hB000, 1'b0, 4'b0100);
    step(16'h1234, 1'b0, 4'h0);
    entry(2, "t5_setwins", 4'h0);
    step(16'h1234, 1'b0, 4'h0);
    step(16'hB000, 1'b0, 4'h0);

    // Reset during the push cycle.
    step(16'h1234, 1'b0, 4'b0010);
    step(16'h1234, 1'b0, 4'h0);
    chk("rm_take", bus.pc_hold, 1'b1);
    step(16'h1234, 1'b0, 4'h0);
    chk("rm_push", bus.push, 1'b1);
    reset = 1'b0;
    #1;
    chk("rm_gate", {get_out(), bus.irq_ack}, {20'b01000_0000_0000_00_00_000, 4'h0});
    step(16'h1234, 1'b0, 4'h0);
    reset = 1'b1;
    step(16'h1234, 1'b0, 4'h0);
    chk("rm_run", {bus.pc_hold, bus.push, bus.s_vec, bus.we3, bus.in_isr},
        5'b00010);

    // Random run against the cycle model.
    reset = 1'b0;
    step(16'h0, 1'b0, 4'h0);
    step(16'h0, 1'b0, 4'h0);
    reset = 1'b1;
    begin
      logic [3:0] pend, msk, prev, rise, ackm, iv, flip;
      logic       gie, isr;
      logic [9:0] va;
      logic       ph, pu, sr, sv, rt, w3, vec_now, isr_exp;
      logic [15:0] op;
      int tk, sel_m, kind;
      pend = 0; msk = 0; prev = 0; gie = 0; isr = 0;
      tk = -100; sel_m = 0;
      for (int c = 0; c < 3000; c++) begin
        kind = $urandom_range(0, 99);
        if (kind < 50) op = {1'b0, 15'($urandom)};
        else if (kind < 65) op = {6'b101010, 6'b0, 4'($urandom)};
        else if (kind < 70) op = 16'hAC00;
        else if (kind < 85) op = 16'hB000;
        else op = 16'hBC00;
        flip = 0;
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 7) == 0) flip[b] = 1'b1;
        iv = irq_c ^ flip;
        step(op, 1'($urandom), iv);

        rise = iv & ~prev;
        ackm = 0; va = 0;
        ph = 0; pu = 0; sr = 0; sv = 0; rt = 0; w3 = 0;
        vec_now = 0;
        isr_exp = isr;
        if (c == tk + 1) begin
          ph = 1; pu = 1; sr = 1;
          sel_m = lowest(pend & msk);
        end else if (c == tk + 2) begin
          sv = 1; vec_now = 1;
          va = 10'h3F0 + 10'(sel_m);
          ackm = 4'b0001 << sel_m;
        end else if (gie && !isr && (pend & msk) != 0) begin
          tk = c; ph = 1;
        end else begin
          if (op[15] == 1'b0) w3 = 1;
          else if (op[15:10] == 6'b101010) begin
            gie = 1; msk = op[3:0];
          end else if (op == 16'hAC00) gie = 0;
          else if (op == 16'hB000) begin
            rt = 1; isr = 0;
          end
        end
        chk($sformatf("rnd_c%0d", c),
            {bus.pc_hold, bus.push, bus.s_ret, bus.s_vec, bus.s_reti,
             bus.we3, bus.in_isr, bus.irq_ack, bus.vec_addr},
            {ph, pu, sr, sv, rt, w3, isr_exp, ackm, va});
        pend = (pend & ~ackm) | rise;
        prev = iv;
        if (vec_now) isr = 1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
